// File: rtl/gate_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gate_bist : exhaustive built-in self-test for a two-input logic gate
// Rev 1.0
// ============================================================================
module gate_bist #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] truth_table,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [1:0] fail_vec
);

   localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t     r_state;
   logic [1:0] r_vec;
   logic [3:0] r_cnt;
   logic [3:0] r_tt;

   logic       w_mismatch;
   logic [2:0] w_err_next;

   assign w_mismatch = (dut_y != r_tt[r_vec]);
   // Saturating add: four samples can never push the count beyond 4.
   assign w_err_next = (w_mismatch && (err_count != 3'd4)) ? err_count + 3'd1 : err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_vec     <= 2'd0;
         r_cnt     <= 4'd0;
         r_tt      <= 4'd0;
         dut_a     <= 1'b0;
         dut_b     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_vec  <= 2'd0;
      end else begin
         done <= 1'b0;
         if (abort && (r_state == S_SETTLE || r_state == S_SAMPLE)) begin
            // Cancel wins over this cycle's compare; partial results stay visible.
            r_state <= S_IDLE;
            busy    <= 1'b0;
            pass    <= 1'b0;
            dut_a   <= 1'b0;
            dut_b   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_tt      <= truth_table;
                     r_vec     <= 2'd0;
                     r_cnt     <= 4'd0;
                     err_count <= 3'd0;
                     fail_vec  <= 2'd0;
                     pass      <= 1'b0;
                     busy      <= 1'b1;
                     dut_a     <= 1'b0;
                     dut_b     <= 1'b0;
                     r_state   <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == c_SETTLE_LAST) begin
                     r_state <= S_SAMPLE;
                  end
               end
               S_SAMPLE: begin
                  err_count <= w_err_next;
                  if (w_mismatch && (err_count == 3'd0)) begin
                     fail_vec <= r_vec;
                  end
                  if (r_vec == 2'd3) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     pass    <= (w_err_next == 3'd0);
                     busy    <= 1'b0;
                     dut_a   <= 1'b0;
                     dut_b   <= 1'b0;
                  end else begin
                     r_vec          <= r_vec + 2'd1;
                     r_cnt          <= 4'd0;
                     {dut_a, dut_b} <= r_vec + 2'd1;
                     r_state        <= S_SETTLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized self-checking bench for gate_bist against an arithmetic
// model of the exhaustive gate test.
module tb_gate_bist;

   localparam int S = 2;
   localparam int N = 4 * (S + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] truth_table = 4'd0;
   logic       dut_a, dut_b, dut_y, busy, done, pass;
   logic [2:0] err_count;
   logic [1:0] fail_vec;
   logic [3:0] gate_tbl = 4'b1110;

   int n_checks = 0;
   int n_fail = 0;
   int exp_err = 0;
   int exp_fail = 0;
   int exp_pass = 0;

   always #5 clk = ~clk;

   // Behavioural gate under test: its own truth table indexed by {a,b}.
   assign dut_y = gate_tbl[{dut_a, dut_b}];

   gate_bist #(.SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .truth_table(truth_table), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_vec(fail_vec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mismatches among the first n_sampled vectors and the first failing one.
   function automatic void model(input logic [3:0] tt, input logic [3:0] gt,
                                 input int n_sampled, output int err, output int first);
      err   = 0;
      first = 0;
      for (int v = 0; v < n_sampled; v++) begin
         if (tt[v] != gt[v]) begin
            if (err == 0) first = v;
            err++;
         end
      end
   endfunction

   task automatic run_test(input logic [3:0] tt, input logic [3:0] gt, input int abort_at,
                           input bit noise, input bit start_in_done);
      int  err, first;
      bit  aborted;
      aborted     = 1'b0;
      gate_tbl    = gt;
      truth_table = tt;
      start       = 1'b1;
      tick();
      start = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_err", err_count, 0);
      check("accept_pass", pass, 0);
      for (int e = 1; e <= N; e++) begin
         abort = (e == abort_at);
         if (noise) begin
            start       = 1'($urandom);
            truth_table = 4'($urandom);
         end
         tick();
         abort = 1'b0;
         start = 1'b0;
         model(tt, gt, (e == abort_at) ? (e - 1) / (S + 1) : e / (S + 1), err, first);
         if (e == abort_at) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pass", pass, 0);
            check("abort_err", err_count, err);
            check("abort_fvec", fail_vec, first);
            check("abort_ab", {dut_a, dut_b}, 0);
            aborted = 1'b1;
            break;
         end
         if (e < N) begin
            check("run_done", done, 0);
            check("run_busy", busy, 1);
            check("run_ab", {dut_a, dut_b}, e / (S + 1));
            check("run_err", err_count, err);
         end else begin
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_pass", pass, (err == 0) ? 1 : 0);
            check("done_err", err_count, err);
            check("done_fvec", fail_vec, first);
            check("done_ab", {dut_a, dut_b}, 0);
         end
      end
      exp_err  = err;
      exp_fail = first;
      exp_pass = (!aborted && err == 0) ? 1 : 0;
      if (!aborted && start_in_done) start = 1'b1;
      tick();
      start = 1'b0;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_pass", pass, exp_pass);
      check("idle_err", err_count, exp_err);
      check("idle_fvec", fail_vec, exp_fail);
   endtask

   task automatic idle_hold(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         abort = 1'($urandom);
         tick();
         check("hold_busy", busy, 0);
         check("hold_done", done, 0);
         check("hold_ab", {dut_a, dut_b}, 0);
         check("hold_pass", pass, exp_pass);
         check("hold_err", err_count, exp_err);
         check("hold_fvec", fail_vec, exp_fail);
      end
      abort = 1'b0;
   endtask

   initial begin
      bit seen_done;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_fvec", fail_vec, 0);
      check("rst_ab", {dut_a, dut_b}, 0);
      rst_n = 1'b1;
      tick();
      idle_hold(2);

      // or2 passes; stuck-at-0 and stuck-at-1 gates fail.
      run_test(4'b1110, 4'b1110, 0, 1'b0, 1'b0);
      run_test(4'b1110, 4'b0000, 0, 1'b0, 1'b0);
      run_test(4'b0000, 4'b1111, 0, 1'b0, 1'b1);
      idle_hold(2);
      // Restart pulses and truth_table changes during the run are ignored.
      run_test(4'b1110, 4'b1110, 0, 1'b1, 1'b0);
      // Abort during SAMPLE of vector 10.
      run_test(4'b1110, 4'b0000, 3 * (S + 1), 1'b0, 1'b0);
      idle_hold(2);

      // Asynchronous reset during SETTLE of vector 01.
      gate_tbl    = 4'b1110;
      truth_table = 4'b0000;
      start       = 1'b1;
      tick();
      start = 1'b0;
      repeat (S + 2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_err", err_count, 0);
      check("mid_rst_fvec", fail_vec, 0);
      check("mid_rst_ab", {dut_a, dut_b}, 0);
      seen_done = 1'b0;
      for (int i = 0; i < N; i++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      check("mid_rst_nodone", seen_done, 0);
      rst_n    = 1'b1;
      exp_err  = 0;
      exp_fail = 0;
      exp_pass = 0;
      tick();
      run_test(4'b1110, 4'b1110, 0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_test(4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0,
                  1'($urandom), 1'($urandom));
         idle_hold(int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
